// File: rtl/twos_decode.sv
// Bit-serial two's-complement to sign-magnitude converter, one word per handshake.
// Latency: out_valid rises W cycles after the accept edge; next accept at least W+2 cycles later.
// Backpressure: result held frozen in DONE until out_ready; in_ready low outside IDLE.
module twos_decode #(
    parameter int W = 12
) (
    input  logic         t_clk,
    input  logic         t_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [W-1:0] out_mag,
    output logic         busy
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    src_q;
    logic [W-1:0]    mag_q;
    logic [CW-1:0]   cnt_q;
    logic            seen_q;
    logic            sign_q;
    logic            valid_q;

    logic            bit_b;
    logic            bit_m;
    logic [W-1:0]    src_d;
    logic [W-1:0]    mag_d;
    logic [CW-1:0]   cnt_d;
    logic            seen_d;

    // One serial step: copy bits up to the first 1 of a negative word, invert the rest.
    always_comb begin
        bit_b  = src_q[0];
        bit_m  = (sign_q & seen_q) ? ~bit_b : bit_b;
        src_d  = {1'b0, src_q[W-1:1]};
        mag_d  = {bit_m, mag_q[W-1:1]};
        cnt_d  = cnt_q + 1'b1;
        seen_d = seen_q | bit_b;
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge t_clk or posedge t_rst) begin
        if (t_rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone is the accept.
                    if (in_valid) begin
                        src_q   <= in_data;
                        sign_q  <= in_data[W-1];
                        seen_q  <= 1'b0;
                        cnt_q   <= '0;
                        mag_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    src_q  <= src_d;
                    mag_q  <= mag_d;
                    seen_q <= seen_d;
                    cnt_q  <= cnt_d;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Result stays frozen; no new accept in the release cycle.
                    if (out_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Handshake status is decoded from state only; no input reaches an output combinationally.
    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = (state_q != S_IDLE);
    end

    assign out_valid = valid_q;
    assign out_sign  = sign_q;
    assign out_mag   = mag_q;

endmodule

// File: tb/tb_twos_decode.sv
// Bench for twos_decode: directed cases with literal results plus randomized traffic
// against a transaction-level reference (sign = msb, magnitude = |x| in W+1-bit arithmetic).
// Outputs sampled on the falling edge; inputs driven 1ns after the rising edge.
module tb_twos_decode;

    localparam int W = 12;

    logic         t_clk;
    logic         t_rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         busy;

    twos_decode #(.W(W)) dut (
        .t_clk    (t_clk),
        .t_rst    (t_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sign (out_sign),
        .out_mag  (out_mag),
        .busy     (busy)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sign is the msb; magnitude is |x| computed with one extra bit so -2^(W-1) is exact.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x);
        int v;
        v = x[W-1] ? (int'(x) - (1 << W)) : int'(x);
        if (v < 0) v = -v;
        return {x[W-1], v[W-1:0]};
    endfunction

    // Transaction-level timing reference: -1 idle, 0..W-1 serial cycles elapsed, W result held.
    int           m_cnt = -1;
    logic [W-1:0] m_word = '0;

    always @(posedge t_clk or posedge t_rst) begin
        if (t_rst) begin
            m_cnt = -1;
        end else if (m_cnt < 0) begin
            if (in_valid) begin
                m_word = in_data;
                m_cnt  = 0;
            end
        end else if (m_cnt < W) begin
            m_cnt = m_cnt + 1;
        end else if (out_ready) begin
            m_cnt = -1;
        end
    end

    // Handshake logs: accept cycles and transferred results.
    int         acc_q[$];
    logic [W:0] out_log[$];
    logic       acc_pend = 1'b0;
    logic       out_pend = 1'b0;
    logic [W:0] out_pend_val = '0;

    always @(negedge t_clk) begin
        acc_pend     = in_valid && in_ready && !t_rst;
        out_pend     = out_valid && out_ready && !t_rst;
        out_pend_val = {out_sign, out_mag};
    end

    always @(posedge t_clk) begin
        cyc = cyc + 1;
        if (acc_pend && !t_rst) acc_q.push_back(cyc);
        if (out_pend && !t_rst) out_log.push_back(out_pend_val);
    end

    // Per-cycle compare against the reference.
    always @(negedge t_clk) begin
        logic [W:0] r;
        if (chk_en && !t_rst) begin
            chk("in_ready", 32'(in_ready), 32'(m_cnt < 0));
            chk("busy", 32'(busy), 32'(m_cnt >= 0));
            chk("out_valid", 32'(out_valid), 32'(m_cnt == W));
            if (m_cnt == W) begin
                r = ref_result(m_word);
                chk("out_sign", 32'(out_sign), 32'(r[W]));
                chk("out_mag", 32'(out_mag), 32'(r[W-1:0]));
            end
        end
    end

    task automatic step();
        @(posedge t_clk);
        #1;
    endtask

    // Send one word, check latency and the literal result, then let it transfer.
    task automatic send(input logic [W-1:0] w, input logic xs, input logic [W-1:0] xm);
        int   t;
        int   acc;
        logic got;
        t = 0;
        while (!in_ready && t < 200) begin step(); t++; end
        in_valid = 1'b1;
        in_data  = w;
        step();
        acc      = cyc;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        got = 1'b0;
        t   = 0;
        while (!got && t < 200) begin
            @(negedge t_clk);
            if (out_valid) got = 1'b1; else t++;
        end
        chk("latency", got ? 32'(cyc - acc) : 32'd999, 32'd12);
        chk("lit_sign", 32'(out_sign), 32'(xs));
        chk("lit_mag", 32'(out_mag), 32'(xm));
        step();
    endtask

    task automatic check_reset_vals();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mag", 32'(out_mag), 32'd0);
        chk("rst_out_sign", 32'(out_sign), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int   n0;
        int   o0;
        int   t;
        int   a0;
        int   guard;
        logic [W:0] e;
        logic [W-1:0] specials [6];

        t_rst     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge t_clk);
        #3;
        check_reset_vals();
        t_rst = 1'b0;
        @(negedge t_clk);
        check_reset_vals();
        chk_en = 1'b1;
        step();

        // Directed values with out_ready held high.
        send(12'h000, 1'b0, 12'h000);
        send(12'h7FF, 1'b0, 12'h7FF);
        send(12'hFFF, 1'b1, 12'h001);
        send(12'hF9C, 1'b1, 12'h064);
        send(12'h800, 1'b1, 12'h800);

        // Back-pressure: result frozen for 5 cycles, in_valid pulses ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 12'hA5C;
        step();
        a0       = cyc;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 200) begin @(negedge t_clk); t++; end
        chk("bp_latency", out_valid ? 32'(cyc - a0) : 32'd999, 32'd12);
        for (int i = 0; i < 5; i++) begin
            step();
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            @(negedge t_clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sign", 32'(out_sign), 32'd1);
            chk("bp_mag", 32'(out_mag), 32'h5A4);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        o0 = out_log.size();
        step();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk("bp_released", 32'(out_valid), 32'd0);
        chk("bp_xfer_count", 32'(out_log.size() - o0), 32'd1);
        if (out_log.size() > o0) chk("bp_xfer_val", 32'(out_log[o0]), 32'h15A4);

        // Throughput with in_valid held high.
        n0 = acc_q.size();
        o0 = out_log.size();
        in_valid = 1'b1;
        in_data  = 12'h001;
        t = 0;
        while (acc_q.size() < n0 + 1 && t < 100) begin step(); t++; end
        in_data = 12'hFFE;
        t = 0;
        while (acc_q.size() < n0 + 2 && t < 100) begin step(); t++; end
        in_valid = 1'b0;
        chk("tp_accepts", 32'(acc_q.size() - n0), 32'd2);
        if (acc_q.size() >= n0 + 2) chk("tp_spacing", 32'(acc_q[n0+1] - acc_q[n0]), 32'd14);
        t = 0;
        while (out_log.size() < o0 + 2 && t < 100) begin step(); t++; end
        chk("tp_outputs", 32'(out_log.size() - o0), 32'd2);
        if (out_log.size() >= o0 + 2) begin
            chk("tp_res0", 32'(out_log[o0]), 32'h0001);
            chk("tp_res1", 32'(out_log[o0+1]), 32'h1002);
        end

        // Reset in the middle of the serial walk.
        o0 = out_log.size();
        in_valid = 1'b1;
        in_data  = 12'h9C4;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #1;
        t_rst = 1'b1;
        #1;
        check_reset_vals();
        @(posedge t_clk);
        #3;
        t_rst = 1'b0;
        repeat (20) step();
        chk("rst_no_output", 32'(out_log.size() - o0), 32'd0);
        send(12'h123, 1'b0, 12'h123);

        // Randomized traffic with random stalls.
        specials[0] = 12'h000; specials[1] = 12'h800; specials[2] = 12'hFFF;
        specials[3] = 12'h7FF; specials[4] = 12'h001; specials[5] = 12'h801;
        n0 = acc_q.size();
        o0 = out_log.size();
        guard = 0;
        while (acc_q.size() < n0 + 1000 && guard < 60000) begin
            step();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (busy && t < 100) begin step(); t++; end
        chk("rand_accepts", 32'(acc_q.size() - n0), 32'd1000);
        chk("rand_in_eq_out", 32'(out_log.size() - o0), 32'(acc_q.size() - n0));
        e = ref_result(12'hF9C);
        chk("ref_pin", 32'(e), 32'h1064);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/twos_decode.md
# twos_decode

Bit-serial two's-complement-to-sign-magnitude converter; the receive-side counterpart of the 12-bit two's-complement inverter. It accepts one W-bit two's-complement word over a valid/ready handshake, walks it LSB-first through a seen-first-one flag over W cycles, and presents sign plus unsigned magnitude on a held output handshake. It sits between the arithmetic datapath and any sign-magnitude consumer (display, serial link formatter).

## Interface
- W, default 12: word width in bits; W >= 2.
- t_clk  input  1  system clock; all state updates on rising edge.
- t_rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  W  two's-complement word, sampled on the accept edge.
- out_valid  output  1  out_sign/out_mag hold a finished result.
- out_ready  input  1  consumer takes the result this cycle.
- out_sign  output  1  1 = negative input.
- out_mag  output  W  unsigned magnitude; -2^(W-1) gives 2^(W-1), no overflow.
- busy  output  1  high in SHIFT or DONE.

## Operation
- Reset (async, any state): state=IDLE, shift/count/flag cleared, out_valid=0, out_sign=0, out_mag=0, busy=0, in_ready=1 once t_rst deasserts. An in-flight word is discarded and never emitted.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Accept edge = in_valid & in_ready. On it: src <= in_data, out_sign <= in_data[W-1], seen <= 0, count <= 0, out_mag <= 0, go to SHIFT. No accept: stay.
- SHIFT: each edge takes b = src[0], right-shifts src. Result bit m = (out_sign & seen) ? ~b : b. Right-shift m into out_mag from the MSB end. seen <= seen | b. count increments. On the edge where count = W-1, go to DONE. After W edges out_mag is aligned with bit 0 = first processed bit.
- Positive input (sign 0): m = b for every bit, so out_mag = in_data.
- Negative input: copy bits up to and including the first 1, then invert. This equals ~x+1 modulo 2^W, read as unsigned.
- Zero: seen stays 0 and out_mag = 0 with sign 0. The input 0x000 never produces sign 1.
- DONE: out_valid=1. out_sign and out_mag stay stable until out_valid & out_ready. On that edge go to IDLE with out_valid <= 0. out_mag and out_sign keep their last values; they are only meaningful while out_valid=1.
- in_valid is ignored outside IDLE. in_data changes outside the accept edge have no effect.
- out_ready is ignored outside DONE.

## Timing
- Accept edge E0.
- SHIFT occupies edges E1..EW. out_valid is high from just after EW.
- With out_ready held high, the output transfers at EW+1 and in_ready=1 in the cycle after.
- Minimum spacing between accepts: W+2 cycles (14 for W=12). DONE does not accept a new word in the same cycle it releases the result.
- Back-pressure: DONE holds indefinitely with outputs frozen and in_ready=0.
- All outputs are registered. in_ready and busy are decoded from state only, with no combinational path from any input.
- Reset during SHIFT or DONE: out_valid drops asynchronously. The first accept after release follows normal timing.

## Test plan
- Reset then idle: t_rst pulse in mid-cycle -> out_valid=0, out_mag=0x000, out_sign=0, in_ready=1, busy=0.
- Directed values, out_ready=1: 0x000->(0,0x000); 0x7FF->(0,0x7FF); 0xFFF->(1,0x001); 0xF9C->(1,0x064); 0x800->(1,0x800). Each out_valid appears exactly 12 cycles after its accept edge.
- Back-pressure: send 0xA5C with out_ready=0 for 5 cycles after out_valid -> (1,0x5A4) stable all 5 cycles, in_ready=0, in_valid pulses ignored. Transfer on the edge where out_ready rises.
- Throughput: in_valid held high with 0x001, then 0xFFE, out_ready=1 -> accepts 14 cycles apart; results (0,0x001), then (1,0x002).
- Reset mid-operation: accept 0x9C4, assert t_rst at shift cycle 6 -> out_valid never rises for that word. After release, 0x123 gives (0,0x123) with normal latency.
- Random: 1000 random words with random out_ready stalls -> sign = x[11] and mag = |x| per the reference model; handshake counts in and out are equal.
